// File: rtl/snn_pkg.sv
// snn_pkg: shared widths, decoder FSM states and 7-segment patterns for the spiking pipeline.
package snn_pkg;
    localparam int SPIKE_CNT_W = 8;
    typedef enum logic {IDLE, RUN} state_t;
    // Active-high {g,f,e,d,c,b,a}; entry 15 leftmost so SEG_TABLE[n] is digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5e, 7'h39, 7'h7c, 7'h77, 7'h6f, 7'h7f,
        7'h07, 7'h7d, 7'h6d, 7'h66, 7'h4f, 7'h5b, 7'h06, 7'h3f
    };
endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational hex digit to active-high 7-segment pattern.
module hex_to_7seg
    import snn_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[nibble];
endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spike rising edges per fixed window and hands the rate out via valid/ready.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter logic [23:0] WINDOW_CYCLES = 24'd10_000_000,
    parameter int          CNT_W         = SPIKE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             spike_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] rate_o,
    output logic             rate_valid_o,
    input  logic             rate_ready_i,
    output logic             overrun_o,
    output logic [6:0]       seg_o,
    output logic             busy_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t           state, state_n;
    logic [23:0]      timer;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic             spike_q, rise, active, terminal, latch, xfer;
    always_comb begin
        state_n = ena ? RUN : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    assign rise     = spike_i & ~spike_q;
    assign active   = (state == RUN) & ena;
    assign terminal = timer == WINDOW_CYCLES - 24'd1;
    assign latch    = active & terminal;
    assign xfer     = rate_valid_o & rate_ready_i;
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + {{(CNT_W-1){1'b0}}, rise};
    assign busy_o   = state == RUN;
    // Dropping ena discards the partial window: timer and cnt only advance while active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer        <= '0;
            cnt          <= '0;
            spike_q      <= 1'b0;
            rate_o       <= '0;
            rate_valid_o <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            spike_q      <= spike_i;
            timer        <= (active && !terminal) ? timer + 24'd1 : '0;
            cnt          <= (active && !terminal) ? cnt_inc : '0;
            rate_o       <= latch ? cnt_inc : rate_o;
            rate_valid_o <= latch | (rate_valid_o & ~xfer);
            overrun_o    <= (latch & rate_valid_o & ~rate_ready_i) | (overrun_o & ~clr_i);
        end
    end
    hex_to_7seg u_seg (
        .nibble(rate_o[3:0]),
        .seg   (seg_o)
    );
endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Sits directly downstream of spiking_neuron and consumes its 1-bit spike output.
- Counts spike rising edges over a fixed window of WINDOW_CYCLES clocks and latches the result as an 8-bit firing rate.
- Presents the rate through a valid/ready handshake and drives a 7-segment hex digit of the rate low nibble for the board display.
- Flags results that were overwritten before being read.

Parameters:
- WINDOW_CYCLES, 24'd10_000_000: window length in clocks; legal range 2..2^24-1.
- CNT_W, 8: spike counter and rate width; counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  block enable; low forces IDLE
- spike_i  input  1  spike from spiking_neuron; may stay high for several cycles
- clr_i  input  1  synchronous clear of overrun_o
- rate_o  output  CNT_W  latched spike count of the last completed window
- rate_valid_o  output  1  rate_o holds an unconsumed result
- rate_ready_i  input  1  consumer accepts rate_o when rate_valid_o is high
- overrun_o  output  1  sticky flag: an unconsumed result was overwritten
- seg_o  output  7  active-high segments {g,f,e,d,c,b,a} showing hex rate_o[3:0]
- busy_o  output  1  high while in RUN

Behaviour:
- Reset (async, rst_n=0): state=IDLE, timer=0, cnt=0, spike_q=0, rate_o=0, rate_valid_o=0, overrun_o=0, busy_o=0. seg_o therefore shows "0" (7'b0111111).
- Edge detect: spike_q <= spike_i every cycle in both states. edge = spike_i & ~spike_q. A pulse held high for N cycles counts once.
- FSM states:
  - IDLE: timer=0, cnt=0.
  - RUN: busy_o=1.
  - IDLE -> RUN when ena=1; the first RUN cycle is timer=0.
  - RUN -> IDLE when ena=0; timer and cnt clear, the partial window is discarded, and rate_o, rate_valid_o and overrun_o hold.
- Timer (RUN): counts 0..WINDOW_CYCLES-1 and wraps to 0. No gap between windows.
- Counter (RUN), non-terminal cycle: cnt <= sat(cnt+edge).
- Counter (RUN), terminal cycle (timer=WINDOW_CYCLES-1):
  - rate_o <= sat(cnt+edge).
  - cnt <= 0. An edge in the terminal cycle belongs to the ending window.
  - rate_valid_o <= 1 on the next clock, so latency is 1 cycle after the terminal cycle.
- Saturation: a count at 2^CNT_W-1 stays there. There is no wrap.
- Handshake:
  - Transfer occurs on a cycle with rate_valid_o & rate_ready_i.
  - Transfer without a latch: rate_valid_o <= 0.
  - rate_o is stable while valid and not transferred, except on overwrite.
- Simultaneous latch and transfer: new value latched, rate_valid_o stays 1, no overrun.
- Latch while rate_valid_o=1 with no transfer: rate_o overwritten, overrun_o <= 1.
- overrun_o clears only on clr_i=1 or reset. If clr_i and a new overrun occur in the same cycle, set wins.
- rate_ready_i is ignored while rate_valid_o=0.
- seg_o: combinational decode of rate_o[3:0] to hex 0-F, standard segment patterns.

Decomposition:
- Shared package snn_pkg holds:
  - SPIKE_CNT_W (=8), shared with spiking_neuron input width.
  - The state enum {IDLE, RUN}.
  - The 16-entry 7-segment pattern constant table.
- One sub-module: hex_to_7seg (4-bit in, 7-bit out, combinational), reused by the top-level display path.

Test Plan (WINDOW_CYCLES=10, CNT_W=8 in bench):
- Reset mid-window with ena=1 and 3 edges counted, rst_n low for 1 cycle -> all outputs 0 immediately (async), seg_o=7'b0111111; the window restarts from timer=0 after ena is seen.
- 4 single-cycle spikes at timer 1,3,5,9, rate_ready_i=1 -> rate_o=4 and rate_valid_o=1 for exactly 1 cycle, 1 cycle after the terminal cycle; seg_o=7'b1100110.
- spike_i held high for 7 cycles inside one window -> rate_o=1. spike_i high continuously across the wrap -> next window rate_o=0.
- WINDOW_CYCLES=300, spike_i toggling every cycle (150 edges), then CNT_W=4 variant -> rate_o=150; 4-bit variant saturates at 15.
- rate_ready_i=0 for two windows with counts 2 then 5 -> rate_o=5, overrun_o=1. Assert ready -> valid drops next cycle, overrun_o stays 1 until clr_i pulse.
- ready asserted exactly in the terminal cycle of window 2 while window 1 result is pending -> window 1 value transferred, window 2 value latched, rate_valid_o stays 1, overrun_o=0. ena dropped mid-window -> busy_o=0, rate_o and rate_valid_o unchanged.
